// File: rtl/timer_counter.sv
// timer_counter: 32-bit down-counting timer with CTRL/PRESET/COUNT registers and
// a maskable interrupt, sequenced by an IDLE/LOAD/CNT/INT state machine.
module timer_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         addr,
  input  logic               we,
  input  logic [COUNT_W-1:0] din,
  output logic [COUNT_W-1:0] dout,
  output logic               irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  localparam logic [1:0]         ADDR_CTRL   = 2'd0;
  localparam logic [1:0]         ADDR_PRESET = 2'd1;
  localparam logic [1:0]         ADDR_COUNT  = 2'd2;
  localparam logic [COUNT_W-1:0] ONE         = COUNT_W'(1);

  state_e             state_q, state_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [COUNT_W-1:0] preset_q, preset_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               pending_q, pending_d;

  logic ctrlEn;
  logic ctrlIm;
  logic autoReload;
  logic wrCtrl;
  logic wrPreset;

  // MODE 1x behaves as one-shot; only 01 reloads.
  assign ctrlEn     = ctrl_q[0];
  assign autoReload = (ctrl_q[2:1] == 2'b01);
  assign ctrlIm     = ctrl_q[3];
  assign wrCtrl     = we && (addr == ADDR_CTRL);
  assign wrPreset   = we && (addr == ADDR_PRESET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ctrl_q    <= 4'd0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  // Pending is raised on the edge that enters INT, so a newly set flag beats a
  // same-edge register write; a CTRL write overrides the automatic EN clear.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;

    if (wrCtrl || wrPreset) begin
      pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (ctrlEn) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = preset_q;
        if (preset_q == '0) begin
          state_d   = INT;
          pending_d = 1'b1;
        end else begin
          state_d = CNT;
        end
      end
      CNT: begin
        if (!ctrlEn) begin
          state_d = IDLE;
        end else if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          count_d   = '0;
          state_d   = INT;
          pending_d = 1'b1;
        end
      end
      INT: begin
        if (autoReload) begin
          pending_d = 1'b0;
          state_d   = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (wrCtrl) begin
      ctrl_d = din[3:0];
    end
    if (wrPreset) begin
      preset_d = din;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = {{(COUNT_W-4){1'b0}}, ctrl_q};
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = '0;
    endcase
  end

  assign irq = ctrlIm & pending_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed stimulus pushes expected dout/irq into a scoreboard
// queue; a negedge monitor pops and compares against the live DUT outputs.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  int expOs[8];
  int expAr[7];
  int expPr[5];
  int expRs[4];
  int expM[4];

  timer_counter #(.COUNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are sampled mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    exp_t e;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      checks++;
      if (dout !== e.dout) begin
        errors++;
        $display("[TB] FAIL %s: got dout=%h, expected dout=%h",
                 e.name, dout, e.dout);
      end
      if (irq !== e.irq) begin
        errors++;
        $display("[TB] FAIL %s: got irq=%b, expected irq=%b",
                 e.name, irq, e.irq);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    we   = 1'b1;
    addr = a;
    din  = d;
    tick();
    we   = 1'b0;
    din  = 32'd0;
  endtask

  task automatic checkOutput(input string nm, input logic [1:0] a,
                             input logic [31:0] expD, input logic expIrq);
    exp_t e;
    addr   = a;
    e.name = nm;
    e.dout = expD;
    e.irq  = expIrq;
    sbQ.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    din   = 32'd0;
    tick();

    checkOutput("rst_ctrl", 0, 32'd0, 1'b0); tick();
    checkOutput("rst_preset", 1, 32'd0, 1'b0); tick();
    checkOutput("rst_count", 2, 32'd0, 1'b0); tick();
    reset = 1'b1;

    // Write on the very first edge after release.
    applyStimulus(1, 32'd5);
    checkOutput("preset5", 1, 32'd5, 1'b0); tick();

    applyStimulus(0, 32'h9);
    expOs = '{0, 0, 5, 4, 3, 2, 1, 0};
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("os5_count_e%0d", k), 2, expOs[k], (k == 7));
      tick();
    end
    checkOutput("os5_ctrl", 0, 32'h8, 1'b1); tick();
    checkOutput("os5_hold", 2, 32'd0, 1'b1); tick();

    applyStimulus(1, 32'd3);
    checkOutput("psw_irqclr", 1, 32'd3, 1'b0); tick();
    checkOutput("psw_nocount", 2, 32'd0, 1'b0); tick();
    tick();
    checkOutput("psw_ctrl", 0, 32'h8, 1'b0); tick();

    // PRESET=0: pending two edges after the enabling write, no underflow.
    applyStimulus(1, 32'd0);
    applyStimulus(0, 32'h9);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("p0_count_e%0d", k), 2, 32'd0, (k >= 2));
      tick();
    end
    checkOutput("p0_ctrl", 0, 32'h8, 1'b1); tick();

    // CTRL write landing on the INT edge keeps EN and clears pending.
    applyStimulus(1, 32'd1);
    applyStimulus(0, 32'h9);
    checkOutput("wi_e0", 2, 32'd0, 1'b0); tick();
    checkOutput("wi_e1", 2, 32'd0, 1'b0); tick();
    checkOutput("wi_e2", 2, 32'd1, 1'b0); tick();
    checkOutput("wi_int", 0, 32'h9, 1'b1);
    applyStimulus(0, 32'h9);
    checkOutput("wi_ctrl", 0, 32'h9, 1'b0); tick();
    checkOutput("wi_e5", 2, 32'd0, 1'b0); tick();
    checkOutput("wi_e6", 2, 32'd1, 1'b0); tick();
    checkOutput("wi_e7", 2, 32'd0, 1'b1); tick();
    checkOutput("wi_e8", 0, 32'h8, 1'b1); tick();

    // Auto-reload with IM=0, then IM set on the edge that enters INT.
    applyStimulus(1, 32'd2);
    applyStimulus(0, 32'h3);
    expAr = '{0, 0, 2, 1, 0, 0, 2};
    for (int k = 0; k < 7; k++) begin
      checkOutput($sformatf("arm_count_e%0d", k), 2, expAr[k], 1'b0);
      tick();
    end
    checkOutput("arm_ctrl", 0, 32'h3, 1'b0);
    applyStimulus(0, 32'hB);
    for (int k = 8; k <= 20; k++) begin
      checkOutput($sformatf("ar_count_e%0d", k), 2,
                  (k % 4 == 2) ? 32'd2 : ((k % 4 == 3) ? 32'd1 : 32'd0),
                  (k % 4 == 0));
      tick();
    end
    applyStimulus(0, 32'h0);
    tick();
    tick();
    checkOutput("stop_hold", 2, 32'd2, 1'b0); tick();

    // Pause after four decrements, then resume through IDLE and LOAD.
    applyStimulus(1, 32'd10);
    applyStimulus(0, 32'h9);
    expPr = '{2, 2, 10, 9, 8};
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("pr_count_e%0d", k), 2, expPr[k], 1'b0);
      tick();
    end
    checkOutput("pr_ctrl", 0, 32'h9, 1'b0);
    applyStimulus(0, 32'h8);
    checkOutput("pr_e6", 2, 32'd6, 1'b0); tick();
    checkOutput("pr_e7", 2, 32'd6, 1'b0); tick();
    checkOutput("pr_e8", 2, 32'd6, 1'b0); tick();
    applyStimulus(0, 32'h9);
    expRs = '{6, 6, 10, 9};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rs_count_e%0d", k + 10), 2, expRs[k], 1'b0);
      tick();
    end
    checkOutput("pr_e14", 2, 32'd8, 1'b0); tick();

    // COUNT is 7 and PRESET is 10 here; reset clears before the next edge.
    reset = 1'b0;
    checkOutput("rst_async_count", 2, 32'd0, 1'b0); tick();
    checkOutput("rst_async_preset", 1, 32'd0, 1'b0); tick();
    checkOutput("rst_async_ctrl", 0, 32'd0, 1'b0); tick();
    reset = 1'b1;
    tick();
    tick();
    checkOutput("post_rst_idle", 2, 32'd0, 1'b0); tick();

    // LOAD uses the pre-write PRESET; a PRESET write in CNT leaves COUNT alone.
    applyStimulus(1, 32'd4);
    applyStimulus(0, 32'h9);
    tick();
    applyStimulus(1, 32'd7);
    checkOutput("ld_count", 2, 32'd4, 1'b0); tick();
    checkOutput("ld_e3", 2, 32'd3, 1'b0); tick();
    checkOutput("ld_preset", 1, 32'd7, 1'b0);
    applyStimulus(1, 32'd9);
    checkOutput("cpw_e5", 2, 32'd1, 1'b0); tick();
    checkOutput("cpw_e6", 2, 32'd0, 1'b1); tick();
    checkOutput("cpw_ctrl", 0, 32'h8, 1'b1); tick();

    reset = 1'b0;
    checkOutput("rst_irq", 0, 32'd0, 1'b0); tick();
    reset = 1'b1;
    applyStimulus(1, 32'hABCD_1234);
    checkOutput("post_rst_wr", 1, 32'hABCD_1234, 1'b0); tick();

    applyStimulus(0, 32'hFFFF_FFF6);
    checkOutput("ctrl_upper", 0, 32'h6, 1'b0); tick();
    applyStimulus(3, 32'h55);
    checkOutput("rsvd_rd", 3, 32'd0, 1'b0); tick();
    applyStimulus(2, 32'h1234);
    checkOutput("count_ro", 2, 32'd0, 1'b0); tick();

    // MODE=10 must behave as one-shot.
    applyStimulus(1, 32'd1);
    applyStimulus(0, 32'hD);
    expM = '{0, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("m10_count_e%0d", k), 2, expM[k], (k == 3));
      tick();
    end
    checkOutput("m10_ctrl", 0, 32'hC, 1'b1); tick();
    checkOutput("m10_hold", 2, 32'd0, 1'b1); tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameter: COUNT_W, 32, width of the PRESET and COUNT registers and of the data bus; only the value 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-004 addr  input  2  word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  write strobe; a write occurs on the clock edge where we=1.
REQ-006 din  input  32  write data.
REQ-007 dout  output  32  combinational read of the register selected by addr.
REQ-008 irq  output  1  interrupt request; drives one HWInt bit of the exception unit.

Function
REQ-009 CTRL fields SHALL be: [0] EN (count enable), [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask, 1=enabled); bits [31:4] SHALL read as 0 and ignore writes.
REQ-010 PRESET SHALL be a 32-bit read/write register; COUNT SHALL be read-only, and writes to COUNT or to reserved address 3 SHALL have no effect; a read of address 3 SHALL return 0.
REQ-011 The FSM SHALL have four states: IDLE, LOAD, CNT, INT.
REQ-012 IDLE: if EN=1 at the edge, next state SHALL be LOAD; otherwise the FSM SHALL stay in IDLE and COUNT SHALL hold.
REQ-013 LOAD: COUNT SHALL be loaded with PRESET, and the next state SHALL be CNT.
REQ-014 CNT, EN=0: the next state SHALL be IDLE and COUNT SHALL hold (pause).
REQ-015 CNT, EN=1, COUNT>1: COUNT SHALL decrement by 1.
REQ-016 CNT, EN=1, COUNT<=1: COUNT SHALL become 0 and the next state SHALL be INT; COUNT SHALL never wrap below 0.
REQ-017 PRESET=0 SHALL produce INT one cycle after LOAD, with no underflow.
REQ-018 INT, one-shot mode: the block SHALL clear CTRL.EN, set the pending flag, and go to IDLE.
REQ-019 INT, auto-reload mode: the block SHALL set the pending flag for exactly one cycle and go to LOAD.
REQ-020 irq SHALL equal IM AND pending.
REQ-021 In one-shot mode, pending SHALL stay set until any write to CTRL or PRESET.
REQ-022 In auto-reload mode, pending SHALL clear automatically on the following edge.
REQ-023 Latency: with EN set and PRESET=N>=1, pending SHALL rise N+2 edges after the edge that wrote EN=1.
REQ-024 A CTRL write SHALL take effect at the same edge; the FSM SHALL act on the new value from the next edge.
REQ-025 A PRESET write during CNT SHALL NOT alter COUNT until the next LOAD.
REQ-026 A CTRL write coinciding with INT in one-shot mode: the written EN value SHALL win over the automatic clear, and pending SHALL be cleared.
REQ-027 A write while in LOAD SHALL update the register, and LOAD SHALL use the pre-write PRESET value.
REQ-028 IM=0 SHALL mask irq only; counting and pending behaviour SHALL be unaffected, and setting IM later with pending=1 SHALL raise irq immediately.

Reset
REQ-029 While reset=0: CTRL, PRESET, COUNT and pending SHALL be 0, the FSM SHALL be IDLE, and irq SHALL be 0, independent of clk.
REQ-030 Reset asserted mid-count SHALL abort immediately; after release the block SHALL stay IDLE until EN is written.
REQ-031 The first edge after release SHALL be able to accept a write.

Verification
REQ-032 PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> COUNT reads 5,4,3,2,1,0; irq rises 7 edges after the CTRL write and stays 1; CTRL reads 0x8.
REQ-033 With irq=1 from REQ-032, write PRESET=3 -> irq falls at that edge; no new count until EN is rewritten.
REQ-034 PRESET=2, CTRL=0xB (EN, auto-reload, IM) -> irq pulses 1 cycle every 4 cycles (LOAD, CNT, CNT, INT) continuously.
REQ-035 PRESET=0, CTRL=0x9 -> irq rises 2 edges after the write; COUNT stays 0 (no 0xFFFFFFFF).
REQ-036 PRESET=10, CTRL=0x9; after 4 decrements write CTRL=0x8 -> COUNT holds at 6; rewrite CTRL=0x9 -> COUNT reloads to 10 (passes through IDLE and LOAD).
REQ-037 Pull reset low mid-count with COUNT=7 and PRESET=10 -> all registers read 0 and irq=0 within the same cycle, before the next clk edge.
